// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a shared-memory multi-cycle RV32I datapath.
// Drives mux selects, write enables and ALU op; stalls on mem_ready, traps illegal opcodes, counts retired instructions.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        cs_zero,
    input  logic        cs_lt,
    input  logic        cs_ltu,
    input  logic        mem_ready,
    output logic        cs_mem_req,
    output logic        cs_adr_src,
    output logic        cs_ir_write,
    output logic        cs_pc_write,
    output logic        cs_reg_write,
    output logic        cs_mem_write,
    output logic [1:0]  cs_alu_src_a,
    output logic [1:0]  cs_alu_src_b,
    output logic [1:0]  cs_result_src,
    output logic [2:0]  cs_imm_src,
    output logic [3:0]  cs_alu_ctrl,
    output logic        cs_illegal,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_LINK = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10;
    localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
    localparam logic [1:0] R_ALUOUT = 2'b00, R_MDR = 2'b01, R_ALU = 2'b10;

    // alt selects SUB for funct3=000 and SRA for funct3=101; callers decide when it is honoured
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_decode = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] imm_for(input logic [6:0] op);
        case (op)
            OP_STORE:         imm_for = IMM_S;
            OP_BR:            imm_for = IMM_B;
            OP_JAL:           imm_for = IMM_J;
            OP_LUI, OP_AUIPC: imm_for = IMM_U;
            default:          imm_for = IMM_I;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = !z;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = !ltu;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cs_mem_req    = 1'b0;
        cs_adr_src    = 1'b0;
        cs_ir_write   = 1'b0;
        cs_pc_write   = 1'b0;
        cs_reg_write  = 1'b0;
        cs_mem_write  = 1'b0;
        cs_alu_src_a  = A_PC;
        cs_alu_src_b  = B_RS2;
        cs_result_src = R_ALUOUT;
        cs_imm_src    = IMM_I;
        cs_alu_ctrl   = ALU_ADD;
        cs_illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                cs_mem_req    = 1'b1;
                cs_alu_src_b  = B_FOUR;
                cs_result_src = R_ALU;
                cs_ir_write   = mem_ready;
                cs_pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                cs_alu_src_a = A_OLDPC;
                cs_alu_src_b = B_IMM;
                cs_imm_src   = imm_for(opcode);
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                cs_alu_src_a = A_RS1;
                cs_alu_src_b = B_IMM;
                cs_imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d      = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                cs_mem_req = 1'b1;
                cs_adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                cs_result_src = R_MDR;
                cs_reg_write  = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                cs_mem_req   = 1'b1;
                cs_adr_src   = 1'b1;
                cs_mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                cs_alu_src_a = A_RS1;
                cs_alu_ctrl  = alu_decode(funct3, funct7b5);
                state_d      = S_ALUWB;
            end
            S_EXEC_I: begin
                // funct7b5 is part of the immediate except for shift-right
                cs_alu_src_a = A_RS1;
                cs_alu_src_b = B_IMM;
                cs_alu_ctrl  = alu_decode(funct3, (funct3 == 3'b101) && funct7b5);
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                cs_reg_write = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                cs_alu_src_a = A_RS1;
                cs_alu_ctrl  = ALU_SUB;
                cs_pc_write  = branch_taken(funct3, cs_zero, cs_lt, cs_ltu);
                state_d      = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_FETCH;
            end
            S_JAL: begin
                cs_alu_src_a = A_OLDPC;
                cs_alu_src_b = B_FOUR;
                cs_pc_write  = 1'b1;
                state_d      = S_ALUWB;
            end
            S_JALR: begin
                cs_alu_src_a  = A_RS1;
                cs_alu_src_b  = B_IMM;
                cs_result_src = R_ALU;
                cs_pc_write   = 1'b1;
                state_d       = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                cs_alu_src_a  = A_OLDPC;
                cs_alu_src_b  = B_FOUR;
                cs_result_src = R_ALU;
                cs_reg_write  = 1'b1;
                state_d       = S_FETCH;
            end
            S_LUI: begin
                cs_alu_src_b = B_IMM;
                cs_imm_src   = IMM_U;
                cs_alu_ctrl  = ALU_PASSB;
                state_d      = S_ALUWB;
            end
            S_AUIPC: begin
                cs_alu_src_a = A_OLDPC;
                cs_alu_src_b = B_IMM;
                cs_imm_src   = IMM_U;
                state_d      = S_ALUWB;
            end
            default: begin
                cs_illegal = 1'b1;
            end
        endcase

        // Reset must silence the memory port and all enables without waiting for a clock
        if (!rst_n) begin
            cs_mem_req   = 1'b0;
            cs_ir_write  = 1'b0;
            cs_pc_write  = 1'b0;
            cs_reg_write = 1'b0;
            cs_mem_write = 1'b0;
            cs_illegal   = 1'b0;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH)) instret_d = instret_q + 32'd1;
    end

    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Moore control FSM that sequences a shared-memory, multi-cycle RV32I datapath. The datapath reuses the register file, ALU, immediate extender and one unified memory port. Each cycle this block drives the datapath's mux selects, write enables and ALU operation from the latched instruction fields and the ALU flags. It also stalls on the memory handshake, traps illegal opcodes and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- cs_zero  in  1  ALU result == 0.
- cs_lt  in  1  signed rs1 < rs2.
- cs_ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the current access this cycle.
- cs_mem_req  out  1  memory access request.
- cs_adr_src  out  1  memory address select: 0 = pc, 1 = alu_out.
- cs_ir_write  out  1  load instruction register and old_pc.
- cs_pc_write  out  1  load pc from writeback result.
- cs_reg_write  out  1  register file write.
- cs_mem_write  out  1  data memory write.
- cs_alu_src_a  out  2  ALU A select: 00 = pc, 01 = old_pc, 10 = rs1 register.
- cs_alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = imm_ext, 10 = constant 4.
- cs_result_src  out  2  writeback select: 00 = alu_out register, 01 = mem data register, 10 = ALU result.
- cs_imm_src  out  3  immediate format: I 000, S 001, B 010, U 011, J 100.
- cs_alu_ctrl  out  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010.
- cs_illegal  out  1  trap flag; sticky until reset.
- instret  out  32  count of retired instructions.
- state  out  4  current state, for debug.

## Operation
Outputs are decoded from state only, with one exception: cs_pc_write in BRANCH and the mem_ready qualification. Every signal not listed for a state is 0, and cs_alu_ctrl defaults to ADD.

- **FETCH**
  - Drives mem_req = 1, adr_src = 0, srcA = pc, srcB = 4, ADD, result_src = 10.
  - ir_write and pc_write are high only when mem_ready = 1.
  - Goes to DECODE on mem_ready; otherwise holds.
- **DECODE**
  - Drives srcA = old_pc, srcB = imm, ADD; imm_src follows the opcode (the branch target lands in alu_out).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC.
  - Any other opcode → ILLEGAL.
- **MEMADR**
  - Drives srcA = rs1, srcB = imm, ADD; imm is I for loads, S for stores.
  - Goes to MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD**
  - Drives mem_req, adr_src = 1, result_src = 00.
  - Goes to MEMWB on mem_ready; otherwise holds.
- **MEMWB**
  - Drives result_src = 01, reg_write.
  - Goes to FETCH.
- **MEMWRITE**
  - Drives mem_req, adr_src = 1, mem_write, held high while waiting.
  - Goes to FETCH on mem_ready.
- **EXEC_R**
  - Drives srcA = rs1, srcB = rs2.
  - ALU op from funct3: 000 is ADD, or SUB when funct7b5 = 1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 is SRL, or SRA when funct7b5 = 1; 110 OR; 111 AND.
  - Goes to ALUWB.
- **EXEC_I**
  - Drives srcA = rs1, srcB = imm I.
  - ALU op uses the same map, except funct3 = 000 is always ADD; funct7b5 is used only when funct3 = 101.
  - Goes to ALUWB.
- **ALUWB**
  - Drives result_src = 00, reg_write.
  - Goes to FETCH.
- **BRANCH**
  - Drives srcA = rs1, srcB = rs2, SUB, result_src = 00.
  - pc_write = taken, where taken is: beq = zero, bne = !zero, blt = lt, bge = !lt, bltu = ltu, bgeu = !ltu.
  - funct3 010 or 011 → ILLEGAL, with no pc_write; otherwise goes to FETCH.
- **JAL**
  - Drives srcA = old_pc, srcB = 4, ADD, result_src = 00, pc_write = 1.
  - Goes to ALUWB, which writes the link value old_pc+4.
- **JALR**
  - Drives srcA = rs1, srcB = imm I, ADD, result_src = 10, pc_write = 1. Clearing bit 0 of the target is done in the datapath.
  - Goes to JALR_LINK.
- **JALR_LINK**
  - Drives srcA = old_pc, srcB = 4, ADD, result_src = 10, reg_write.
  - Goes to FETCH.
- **LUI**
  - Drives srcB = imm U, PASSB.
  - Goes to ALUWB.
- **AUIPC**
  - Drives srcA = old_pc, srcB = imm U, ADD.
  - Goes to ALUWB.
- **ILLEGAL**
  - Drives cs_illegal = 1; all enables and mem_req are 0.
  - Stays in ILLEGAL until reset.
- **instret**
  - Increments by 1 on every transition into FETCH from a non-FETCH state.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- **Reset**
  - While rst_n = 0: state = FETCH, instret = 0, cs_illegal = 0, and every enable and mem_req is forced to 0.
  - Reset may be asserted in any state, mid-instruction included. It aborts immediately and takes effect asynchronously.
  - The first request is issued in the first cycle after rst_n rises.
- **Cycles per instruction** with mem_ready held at 1: load 5; store 4; R, I, LUI, AUIPC, JAL and JALR 4; branch 3.
- **Wait states:** each cycle with mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle. During a stall all outputs hold and no write enable pulses, except mem_write in MEMWRITE.
- **No skid:** mem_ready is sampled only while mem_req = 1.
- **Write-enable width:** pc_write, ir_write and reg_write are each exactly 1 cycle wide per event.

## Test plan
- **R-type:** opcode 0110011, funct3 000, funct7b5 1, mem_ready = 1 → states FETCH, DECODE, EXEC_R, ALUWB. alu_ctrl = 0001 in EXEC_R, reg_write only in ALUWB, instret 0 → 1.
- **Load with wait states:** lw (opcode 0000011) with mem_ready low for 3 cycles in MEMREAD → 8 total cycles. reg_write is high once with result_src = 01.
- **Branches:**
  - beq, cs_zero = 1 → pc_write in BRANCH, 3 cycles.
  - bne, cs_zero = 1 → no pc_write.
  - bltu, cs_ltu = 1 → pc_write.
- **Fetch stall:** mem_ready = 0 for 2 cycles in FETCH → ir_write and pc_write stay low, then pulse together for 1 cycle.
- **Illegal opcode:** opcode 0000000 → DECODE, then ILLEGAL. cs_illegal = 1 and stays high, no enables, instret frozen; rst_n low clears all.
- **Reset mid-operation:** rst_n pulsed low during MEMWRITE → mem_write drops without waiting for a clock, state = FETCH, instret = 0.
